ppu_instr_encoder_loader: RTL and testbench
===========================================

Name: ppu_instr_encoder_loader

Overview:
- Inverse of the PPU decode stage: accepts a stream of symbolic instructions (mnemonic code plus register, immediate and target fields) and packs each one into a 32-bit MIPS word.
- Writes the packed words sequentially into instruction memory through a valid/ready-style memory port.
- Used by testbench and boot logic to preload programs before the pipeline is released from reset.

Parameters:
- BASE_ADDR, 0, byte address of the first word written after start.
- DEPTH, 256, maximum words per load; must be a power of two.
- ADDR_W, 32, width of mem_addr.
- CNT_W, $clog2(DEPTH)+1, width of word_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins a load session; honoured only in IDLE.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder can accept an instruction.
- in_mnem  in  6  mnemonic code from ppu_isa_pkg.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  J/JAL target field.
- in_last  in  1  marks the final instruction of the session.
- mem_en  out  1  memory access request.
- mem_rw  out  1  1 = write (the only value driven while mem_en=1).
- mem_addr  out  ADDR_W  byte address, word-aligned.
- mem_wdata  out  32  packed instruction.
- mem_ready  in  1  memory accepted the current write.
- word_count  out  CNT_W  words written this session.
- err_unknown  out  1  sticky; an unsupported mnemonic was seen.
- overflow  out  1  sticky; DEPTH was exceeded.
- done  out  1  single-cycle pulse at session end.

Behaviour:
- States: IDLE, RUN, WRITE, DONE.
- Reset (reset_n=0 at a clock edge, from any state):
  - State returns to IDLE.
  - in_ready, mem_en, mem_rw, done, err_unknown and overflow are 0.
  - mem_addr = BASE_ADDR, mem_wdata = 0, word_count = 0.
  - A write in progress is abandoned.
- IDLE:
  - in_ready=0.
  - On start=1: mem_addr<=BASE_ADDR, word_count<=0, err_unknown<=0, overflow<=0, then go to RUN.
- RUN:
  - in_ready=1.
  - Handshake in_valid & in_ready: the packed word is registered into mem_wdata, in_last is captured, and the state goes to WRITE. Latency from accept to mem_en is 1 cycle.
  - If word_count==DEPTH at accept: the word is dropped, overflow<=1, and the state goes to DONE.
- WRITE:
  - mem_en=1, mem_rw=1, in_ready=0.
  - mem_addr and mem_wdata are held stable until mem_ready=1.
  - On mem_ready: mem_addr<=mem_addr+4 (wraps modulo 2^ADDR_W) and word_count++.
  - Next state is DONE if the captured last=1, otherwise RUN.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Encoding (combinational packer, registered on accept):
  - R-type ALU ops (ADD, ADDU, SUB, SUBU, SLT, SLTU, AND, OR, XOR, NOR, SLLV, SRLV, SRAV, MOVN, MOVZ): {000000, rs, rt, rd, 00000, funct}.
  - SLL, SRL, SRA: rs field forced to 0; shamt is taken from in_shamt.
  - MFHI, MFLO: only rd is kept. MTHI, MTLO, JR: only rs is kept. JALR: rs, and rd (31 if in_rd=0).
  - Traps (TEQ, TGE, TGEU, TLT, TLTU, TNE): rs and rt; bits 15:6 = 0.
  - CLO, CLZ: opcode 011100, rt field = rd field = in_rd.
  - MFC0, MTC0: opcode 010000, rs field 00000 / 00100, low 11 bits 0.
  - REGIMM (BGEZ, BGEZAL, BLTZ, BLTZAL, BAL, TEQI, TGEI, TGEIU, TLTI, TLTIU, TNEI): opcode 000001, rt field = sub-code. BAL also forces rs=0.
  - BEQ, BNE, BLEZ, BGTZ: opcode, rs, rt (rt forced 0 for BLEZ/BGTZ), imm.
  - B: encoded as BEQ $0,$0,imm.
  - I-type arithmetic, loads and stores (LB, LBU, LH, LHU, LW, SB, SH, SW): {op, rs, rt, imm}. LUI forces rs=0.
  - J, JAL: {op, target}.
  - NOP: 32'h0.
  - Unknown mnemonic: the word is NOP, err_unknown<=1, and the write still occurs.

Decomposition:
- ppu_isa_pkg holds:
  - Opcode, funct and REGIMM rt-code constants; SW is 101011 and is distinct from any doubleword op.
  - The mnemonic enum (6-bit).
  - MEM_RW_WRITE=1.
- The control unit shares this package.
- One sub-module, ppu_instr_packer: purely combinational, in_mnem plus fields -> {word[31:0], unknown}.
- The FSM, counters and memory port live in the top module.

Test Plan:
- ADDU rd=3 rs=1 rt=2, in_last=1, mem_ready=1 -> mem_wdata=0x00221821 at mem_addr=BASE_ADDR, done pulses, word_count=1.
- Three-word session with ADDIU rt=5 rs=0 imm=0x0010, LBU rt=4 rs=29 imm=0xFFFC, and J target=0x40 (last):
  - mem_wdata = 0x24050010, 0x93A4FFFC, 0x08000040.
  - mem_addr = 0x0, 0x4, 0x8.
  - word_count=3.
- B imm=0x0003 and SLL all-zero -> 0x10000003 and 0x00000000; an unknown mnemonic 0x3F -> 0x00000000 written and err_unknown=1.
- mem_ready held low for 3 cycles during WRITE -> mem_en, mem_addr and mem_wdata stable, in_ready=0; the write completes on the 4th cycle.
- DEPTH=4 with 5 words offered -> 4 writes, 5th word dropped, overflow=1, done pulses, word_count=4.
- reset_n=0 during WRITE -> next cycle IDLE, mem_en=0, word_count=0; a start issued mid-RUN has no effect.

Source files
------------

// File: rtl/ppu_isa_pkg.sv
// ppu_isa_pkg: opcode/funct/REGIMM constants and the symbolic mnemonic set shared by
// the PPU decode/control stages and the instruction encoder-loader.
// Pure declarations plus small field-packing helpers; no state.
package ppu_isa_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_COP0     = 6'b010000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_LHU      = 6'b100101;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  // Single-word store; not to be confused with the 64-bit SD opcode (111111).
  localparam logic [5:0] OP_SW       = 6'b101011;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_MOVN = 6'h0B;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_TGE  = 6'h30;
  localparam logic [5:0] FN_TGEU = 6'h31;
  localparam logic [5:0] FN_TLT  = 6'h32;
  localparam logic [5:0] FN_TLTU = 6'h33;
  localparam logic [5:0] FN_TEQ  = 6'h34;
  localparam logic [5:0] FN_TNE  = 6'h36;

  // SPECIAL2 function codes
  localparam logic [5:0] FN2_CLZ = 6'h20;
  localparam logic [5:0] FN2_CLO = 6'h21;

  // COP0 rs-field sub-ops
  localparam logic [4:0] CP0_MF = 5'b00000;
  localparam logic [4:0] CP0_MT = 5'b00100;

  // REGIMM rt-field sub-codes
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_TGEI   = 5'h08;
  localparam logic [4:0] RT_TGEIU  = 5'h09;
  localparam logic [4:0] RT_TLTI   = 5'h0A;
  localparam logic [4:0] RT_TLTIU  = 5'h0B;
  localparam logic [4:0] RT_TEQI   = 5'h0C;
  localparam logic [4:0] RT_TNEI   = 5'h0E;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // Memory port direction value for a write
  localparam logic MEM_RW_WRITE = 1'b1;

  // Symbolic mnemonics. The 6-bit space holds 63 codes (0x00..0x3E); 0x3F is
  // deliberately left unassigned so it always decodes as unknown.
  typedef enum logic [5:0] {
    M_NOP,
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR,
    M_SLLV, M_SRLV, M_SRAV, M_MOVN, M_MOVZ,
    M_SLL, M_SRL, M_SRA,
    M_MFHI, M_MFLO, M_MTHI, M_MTLO, M_JR, M_JALR,
    M_TEQ, M_TGE, M_TGEU, M_TLT, M_TLTU, M_TNE,
    M_CLO, M_CLZ, M_MFC0, M_MTC0,
    M_BGEZ, M_BGEZAL, M_BLTZ, M_BLTZAL, M_BAL,
    M_TEQI, M_TGEI, M_TGEIU, M_TLTI, M_TLTIU, M_TNEI,
    M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_B,
    M_ADDIU, M_LUI,
    M_LB, M_LBU, M_LH, M_LHU, M_LW, M_SB, M_SH, M_SW,
    M_J, M_JAL
  } mnem_e;

  // R-type layout {op, rs, rt, rd, shamt, funct}
  function automatic logic [31:0] pack_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // I-type layout {op, rs, rt, imm}
  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/ppu_instr_packer.sv
// ppu_instr_packer: maps a symbolic instruction onto its 32-bit MIPS encoding.
// Purely combinational; unknown mnemonics yield NOP with the unknown flag raised.
// No handshake of its own; the loader registers the result on accept.
import ppu_isa_pkg::*;

module ppu_instr_packer (
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        unknown
);

  logic [5:0] fn;
  logic [4:0] ri_code;
  logic [5:0] i_op;
  logic [4:0] link_rd;

  // JALR with no explicit destination links through $31
  assign link_rd = (rd == 5'd0) ? 5'd31 : rd;

  // Per-mnemonic sub-codes: SPECIAL funct, REGIMM rt code, I-type opcode
  always_comb begin
    fn      = 6'h00;
    ri_code = 5'h00;
    i_op    = 6'h00;
    case (mnem)
      M_ADD:    fn = FN_ADD;
      M_ADDU:   fn = FN_ADDU;
      M_SUB:    fn = FN_SUB;
      M_SUBU:   fn = FN_SUBU;
      M_SLT:    fn = FN_SLT;
      M_SLTU:   fn = FN_SLTU;
      M_AND:    fn = FN_AND;
      M_OR:     fn = FN_OR;
      M_XOR:    fn = FN_XOR;
      M_NOR:    fn = FN_NOR;
      M_SLLV:   fn = FN_SLLV;
      M_SRLV:   fn = FN_SRLV;
      M_SRAV:   fn = FN_SRAV;
      M_MOVN:   fn = FN_MOVN;
      M_MOVZ:   fn = FN_MOVZ;
      M_SLL:    fn = FN_SLL;
      M_SRL:    fn = FN_SRL;
      M_SRA:    fn = FN_SRA;
      M_MFHI:   fn = FN_MFHI;
      M_MFLO:   fn = FN_MFLO;
      M_MTHI:   fn = FN_MTHI;
      M_MTLO:   fn = FN_MTLO;
      M_JR:     fn = FN_JR;
      M_JALR:   fn = FN_JALR;
      M_TEQ:    fn = FN_TEQ;
      M_TGE:    fn = FN_TGE;
      M_TGEU:   fn = FN_TGEU;
      M_TLT:    fn = FN_TLT;
      M_TLTU:   fn = FN_TLTU;
      M_TNE:    fn = FN_TNE;
      M_CLO:    fn = FN2_CLO;
      M_CLZ:    fn = FN2_CLZ;
      M_BGEZ:   ri_code = RT_BGEZ;
      M_BGEZAL: ri_code = RT_BGEZAL;
      M_BLTZ:   ri_code = RT_BLTZ;
      M_BLTZAL: ri_code = RT_BLTZAL;
      M_BAL:    ri_code = RT_BGEZAL;
      M_TEQI:   ri_code = RT_TEQI;
      M_TGEI:   ri_code = RT_TGEI;
      M_TGEIU:  ri_code = RT_TGEIU;
      M_TLTI:   ri_code = RT_TLTI;
      M_TLTIU:  ri_code = RT_TLTIU;
      M_TNEI:   ri_code = RT_TNEI;
      M_BEQ:    i_op = OP_BEQ;
      M_BNE:    i_op = OP_BNE;
      M_BLEZ:   i_op = OP_BLEZ;
      M_BGTZ:   i_op = OP_BGTZ;
      M_ADDIU:  i_op = OP_ADDIU;
      M_LB:     i_op = OP_LB;
      M_LBU:    i_op = OP_LBU;
      M_LH:     i_op = OP_LH;
      M_LHU:    i_op = OP_LHU;
      M_LW:     i_op = OP_LW;
      M_SB:     i_op = OP_SB;
      M_SH:     i_op = OP_SH;
      M_SW:     i_op = OP_SW;
      M_J:      i_op = OP_J;
      M_JAL:    i_op = OP_JAL;
      default:  fn = 6'h00;
    endcase
  end

  // Field assembly by instruction class
  always_comb begin
    word    = 32'h0000_0000;
    unknown = 1'b0;
    case (mnem)
      M_NOP: word = 32'h0000_0000;
      M_ADD, M_ADDU, M_SUB, M_SUBU, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR,
      M_SLLV, M_SRLV, M_SRAV, M_MOVN, M_MOVZ:
        word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, fn);
      M_SLL, M_SRL, M_SRA:
        word = pack_r(OP_SPECIAL, 5'd0, rt, rd, shamt, fn);
      M_MFHI, M_MFLO:
        word = pack_r(OP_SPECIAL, 5'd0, 5'd0, rd, 5'd0, fn);
      M_MTHI, M_MTLO, M_JR:
        word = pack_r(OP_SPECIAL, rs, 5'd0, 5'd0, 5'd0, fn);
      M_JALR:
        word = pack_r(OP_SPECIAL, rs, 5'd0, link_rd, 5'd0, fn);
      M_TEQ, M_TGE, M_TGEU, M_TLT, M_TLTU, M_TNE:
        word = {OP_SPECIAL, rs, rt, 10'd0, fn};
      M_CLO, M_CLZ:
        word = pack_r(OP_SPECIAL2, rs, rd, rd, 5'd0, fn);
      M_MFC0:
        word = {OP_COP0, CP0_MF, rt, rd, 11'd0};
      M_MTC0:
        word = {OP_COP0, CP0_MT, rt, rd, 11'd0};
      M_BGEZ, M_BGEZAL, M_BLTZ, M_BLTZAL,
      M_TEQI, M_TGEI, M_TGEIU, M_TLTI, M_TLTIU, M_TNEI:
        word = pack_i(OP_REGIMM, rs, ri_code, imm);
      M_BAL:
        word = pack_i(OP_REGIMM, 5'd0, ri_code, imm);
      M_BEQ, M_BNE:
        word = pack_i(i_op, rs, rt, imm);
      M_BLEZ, M_BGTZ:
        word = pack_i(i_op, rs, 5'd0, imm);
      M_B:
        word = pack_i(OP_BEQ, 5'd0, 5'd0, imm);
      M_ADDIU, M_LB, M_LBU, M_LH, M_LHU, M_LW, M_SB, M_SH, M_SW:
        word = pack_i(i_op, rs, rt, imm);
      M_LUI:
        word = pack_i(OP_LUI, 5'd0, rt, imm);
      M_J, M_JAL:
        word = {i_op, target};
      default: begin
        word    = 32'h0000_0000;
        unknown = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ppu_instr_encoder_loader.sv
// ppu_instr_encoder_loader: packs symbolic instructions and writes them to instruction memory.
// Latency: accept -> mem_en one cycle; one word in flight, in_ready low while writing.
// Backpressure: mem_ready low holds address/data stable; words beyond DEPTH end the session.
import ppu_isa_pkg::*;

module ppu_instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  word_count,
  output logic              err_unknown,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_e      state;
  logic        last_q;
  logic [31:0] pk_word;
  logic        pk_unknown;

  ppu_instr_packer u_packer (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pk_word),
    .unknown (pk_unknown)
  );

  // Session FSM with registered handshake, memory-port and status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      last_q      <= 1'b0;
      in_ready    <= 1'b0;
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= 32'h0000_0000;
      word_count  <= '0;
      err_unknown <= 1'b0;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_addr    <= BASE_ADDR;
            word_count  <= '0;
            err_unknown <= 1'b0;
            overflow    <= 1'b0;
            in_ready    <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (word_count == FULL_CNT) begin
              // Load window already full: drop this word and close the session
              overflow <= 1'b1;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              mem_wdata <= pk_word;
              last_q    <= in_last;
              mem_en    <= 1'b1;
              mem_rw    <= MEM_RW_WRITE;
              state     <= ST_WRITE;
              if (pk_unknown) begin
                err_unknown <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= mem_addr + ADDR_W'(4);
            word_count <= word_count + CNT_W'(1);
            if (last_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_instr_encoder_loader.sv
// Directed bench for ppu_instr_encoder_loader (DEPTH=4, BASE_ADDR=0).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
// Expected words are hand-assembled MIPS encodings.
import ppu_isa_pkg::*;

module tb_ppu_instr_encoder_loader;

  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [CNT_W-1:0] word_count;
  logic        err_unknown;
  logic        overflow;
  logic        done;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  ppu_instr_encoder_loader #(
    .ADDR_W    (32),
    .BASE_ADDR (32'h0),
    .DEPTH     (4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mnem     (in_mnem),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_shamt    (in_shamt),
    .in_imm      (in_imm),
    .in_target   (in_target),
    .in_last     (in_last),
    .mem_en      (mem_en),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .word_count  (word_count),
    .err_unknown (err_unknown),
    .overflow    (overflow),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tg, input logic last);
    in_mnem   = m;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tg;
    in_last   = last;
  endtask

  task automatic open_session(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Offer one instruction with mem_ready high: accept edge, then write edge
  task automatic write_word(input string tag, input logic [31:0] exp_word,
                            input logic [31:0] exp_addr);
    in_valid  = 1'b1;
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
    chk({tag, "_wdata"}, mem_wdata, exp_word);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    mem_ready = 1'b0;
    drive(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_flags", {29'd0, done, err_unknown, overflow}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Single ADDU, last
    open_session("s1");
    drive(M_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    chk("s1_rw_idle", 32'(mem_rw), 32'd0);
    in_valid  = 1'b1;
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s1_mem_en", 32'(mem_en), 32'd1);
    chk("s1_mem_rw", 32'(mem_rw), 32'd1);
    chk("s1_in_ready_wr", 32'(in_ready), 32'd0);
    chk("s1_wdata", mem_wdata, 32'h0022_1821);
    chk("s1_addr", mem_addr, 32'h0);
    tick();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_count", 32'(word_count), 32'd1);
    chk("s1_mem_en_off", 32'(mem_en), 32'd0);
    tick();
    chk("s1_done_pulse", 32'(done), 32'd0);
    chk("s1_idle_in_ready", 32'(in_ready), 32'd0);

    // Three-word session: ADDIU, LBU, J
    open_session("s2");
    chk("s2_addr_restart", mem_addr, 32'h0);
    chk("s2_count_restart", 32'(word_count), 32'd0);
    drive(M_ADDIU, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0);
    write_word("s2_addiu", 32'h2405_0010, 32'h0);
    chk("s2_back_to_run", 32'(in_ready), 32'd1);
    drive(M_LBU, 5'd29, 5'd4, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b0);
    write_word("s2_lbu", 32'h93A4_FFFC, 32'h4);
    drive(M_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b1);
    write_word("s2_j", 32'h0800_0040, 32'h8);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_count", 32'(word_count), 32'd3);
    chk("s2_addr_end", mem_addr, 32'hC);
    tick();

    // B, SLL zero, SRA, unknown 0x3F
    open_session("s3");
    drive(M_B, 5'd7, 5'd9, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b0);
    write_word("s3_b", 32'h1000_0003, 32'h0);
    drive(M_SLL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
    write_word("s3_sll", 32'h0000_0000, 32'h4);
    chk("s3_err_before", 32'(err_unknown), 32'd0);
    drive(M_SRA, 5'd3, 5'd4, 5'd5, 5'd2, 16'h0, 26'h0, 1'b0);
    write_word("s3_sra", 32'h0004_2883, 32'h8);
    drive(6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h0, 1'b1);
    write_word("s3_unknown", 32'h0000_0000, 32'hC);
    chk("s3_err_unknown", 32'(err_unknown), 32'd1);
    chk("s3_count", 32'(word_count), 32'd4);
    chk("s3_done", 32'(done), 32'd1);
    tick();

    // mem_ready stall, then start pulse mid-RUN
    open_session("s4");
    chk("s4_err_cleared", 32'(err_unknown), 32'd0);
    drive(M_SW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
    in_valid  = 1'b1;
    mem_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s4_stall%0d_en", i), 32'(mem_en), 32'd1);
      chk($sformatf("s4_stall%0d_wdata", i), mem_wdata, 32'hAFA8_0004);
      chk($sformatf("s4_stall%0d_addr", i), mem_addr, 32'h0);
      chk($sformatf("s4_stall%0d_rdy", i), 32'(in_ready), 32'd0);
      tick();
    end
    chk("s4_cycle4_en", 32'(mem_en), 32'd1);
    chk("s4_cycle4_count", 32'(word_count), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("s4_complete_en", 32'(mem_en), 32'd0);
    chk("s4_complete_count", 32'(word_count), 32'd1);
    chk("s4_complete_addr", mem_addr, 32'h4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s4_midrun_start_rdy", 32'(in_ready), 32'd1);
    chk("s4_midrun_start_count", 32'(word_count), 32'd1);
    chk("s4_midrun_start_addr", mem_addr, 32'h4);
    drive(M_LUI, 5'd7, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
    write_word("s4_lui", 32'h3C01_1234, 32'h4);
    chk("s4_count", 32'(word_count), 32'd2);
    chk("s4_done", 32'(done), 32'd1);
    tick();

    // Overflow: DEPTH=4, five words offered, none marked last
    open_session("s5");
    drive(M_MFHI, 5'd9, 5'd9, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    write_word("s5_mfhi", 32'h0000_1010, 32'h0);
    drive(M_JALR, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
    write_word("s5_jalr", 32'h0080_F809, 32'h4);
    drive(M_TEQ, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
    write_word("s5_teq", 32'h0064_0034, 32'h8);
    drive(M_CLZ, 5'd5, 5'd0, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
    write_word("s5_clz", 32'h70A6_3020, 32'hC);
    chk("s5_full_count", 32'(word_count), 32'd4);
    chk("s5_no_ovf_yet", 32'(overflow), 32'd0);
    drive(M_MTC0, 5'd0, 5'd9, 5'd12, 5'd0, 16'h0, 26'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s5_overflow", 32'(overflow), 32'd1);
    chk("s5_done", 32'(done), 32'd1);
    chk("s5_dropped_no_en", 32'(mem_en), 32'd0);
    chk("s5_count", 32'(word_count), 32'd4);
    chk("s5_addr", mem_addr, 32'h10);
    tick();
    chk("s5_done_pulse", 32'(done), 32'd0);

    // Reset during WRITE
    open_session("s6");
    chk("s6_ovf_cleared", 32'(overflow), 32'd0);
    drive(M_BAL, 5'd7, 5'd0, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0);
    in_valid  = 1'b1;
    mem_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("s6_wr_en", 32'(mem_en), 32'd1);
    chk("s6_wdata", mem_wdata, 32'h0411_0010);
    reset_n = 1'b0;
    tick();
    chk("s6_rst_en", 32'(mem_en), 32'd0);
    chk("s6_rst_count", 32'(word_count), 32'd0);
    chk("s6_rst_wdata", mem_wdata, 32'h0);
    chk("s6_rst_rdy", 32'(in_ready), 32'd0);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("s6_idle_rdy", 32'(in_ready), 32'd0);
    chk("s6_idle_en", 32'(mem_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
